// File: rtl/cdma_rd_sched.sv
// Read-DMA scheduler: round-robin grant across requesters, chunked command issue
// to the copy engine, and an in-order completion FIFO that routes done pulses.
module cdma_rd_sched #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned ADDR_BITS       = 32,  // HBM address width
  parameter int unsigned LEN_BITS        = 32,  // HBM byte-length width
  parameter int unsigned CHUNK_LOG       = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [N_REQ*LEN_BITS-1:0]     req_len,
  output logic [N_REQ-1:0]              req_done,
  output logic                          dma_ctrl_valid,
  input  logic                          dma_stat_ready,
  output logic [ADDR_BITS-1:0]          dma_ctrl_addr,
  output logic [LEN_BITS-1:0]           dma_ctrl_len,
  output logic                          dma_ctrl_ctl,
  input  logic                          dma_stat_done,
  output logic [$clog2(N_REQ)-1:0]      rd_owner,
  output logic                          rd_owner_valid
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_BITS-1:0] CHUNK = LEN_BITS'(64'd1 << CHUNK_LOG);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t               r_state;
  logic [N_REQ-1:0]     r_req_ready;
  logic [N_REQ-1:0]     r_req_done;
  logic [IDX_W-1:0]     r_last_grant;
  logic [IDX_W-1:0]     r_owner;
  logic                 r_dma_valid;
  logic [ADDR_BITS-1:0] r_dma_addr;
  logic [LEN_BITS-1:0]  r_dma_len;
  logic                 r_dma_ctl;
  logic [LEN_BITS-1:0]  r_rem;
  logic [IDX_W-1:0]     r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [CNT_W-1:0]     r_count;

  logic [ADDR_BITS-1:0] w_addr_arr [N_REQ];
  logic [LEN_BITS-1:0]  w_len_arr  [N_REQ];
  logic                 w_gnt_found;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic [IDX_W-1:0]     w_cand;
  logic [ADDR_BITS-1:0] w_sel_addr;
  logic [LEN_BITS-1:0]  w_sel_len;
  logic                 w_grant;
  logic                 w_xfer;
  logic                 w_push;
  logic                 w_pop;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 w_full_nxt;
  logic [LEN_BITS-1:0]  w_rem_after;

  function automatic logic [LEN_BITS-1:0] f_chunk(input logic [LEN_BITS-1:0] rem);
    return (rem > CHUNK) ? CHUNK : rem;
  endfunction

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign w_len_arr[g]  = req_len[g*LEN_BITS +: LEN_BITS];
  end

  // Round-robin search beginning just after the last granted index
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_cand = IDX_W'((32'(r_last_grant) + i) % N_REQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  assign w_sel_addr  = w_addr_arr[w_gnt_idx];
  assign w_sel_len   = w_len_arr[w_gnt_idx];
  assign w_grant     = (r_state == S_IDLE) && w_gnt_found && (r_req_ready == '0);
  assign w_xfer      = (r_state == S_ISSUE) && r_dma_valid && dma_stat_ready;
  assign w_push      = w_xfer && r_dma_ctl;
  assign w_pop       = dma_stat_done && (r_count != '0);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_full_nxt  = (w_count_nxt == CNT_W'(MAX_OUTSTANDING));
  assign w_rem_after = r_rem - r_dma_len;

  // Control state: FSM, handshakes, completion FIFO pointers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_req_ready  <= '0;
      r_req_done   <= '0;
      r_dma_valid  <= 1'b0;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_req_ready <= '0;
      r_req_done  <= '0;
      if (w_pop) begin
        r_req_done <= N_REQ'(1) << r_fifo[r_rptr];
        r_rptr     <= f_ptr_inc(r_rptr);
      end
      if (w_push) r_wptr <= f_ptr_inc(r_wptr);
      r_count <= w_count_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_req_ready  <= N_REQ'(1) << w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            if (w_sel_len != '0) begin
              r_state     <= S_ISSUE;
              r_dma_valid <= !((w_sel_len <= CHUNK) && w_full_nxt);
            end
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            if (r_dma_ctl) begin
              r_state     <= S_IDLE;
              r_dma_valid <= 1'b0;
            end else begin
              r_dma_valid <= !((w_rem_after <= CHUNK) && w_full_nxt);
            end
          end else if (!r_dma_valid) begin
            // Last chunk waits here until the completion FIFO has room
            r_dma_valid <= !(r_dma_ctl && w_full_nxt);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: latched request, current chunk and FIFO storage
  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wptr] <= r_owner;
    if (w_grant) begin
      r_owner    <= w_gnt_idx;
      r_rem      <= w_sel_len;
      r_dma_addr <= w_sel_addr;
      r_dma_len  <= f_chunk(w_sel_len);
      r_dma_ctl  <= (w_sel_len <= CHUNK);
    end else if (w_xfer) begin
      r_rem      <= w_rem_after;
      r_dma_addr <= r_dma_addr + ADDR_BITS'(r_dma_len);
      r_dma_len  <= f_chunk(w_rem_after);
      r_dma_ctl  <= (w_rem_after <= CHUNK);
    end
  end

  assign req_ready      = r_req_ready;
  assign req_done       = r_req_done;
  assign dma_ctrl_valid = r_dma_valid;
  assign dma_ctrl_addr  = r_dma_addr;
  assign dma_ctrl_len   = r_dma_len;
  assign dma_ctrl_ctl   = r_dma_ctl;
  assign rd_owner       = r_fifo[r_rptr];
  assign rd_owner_valid = (r_count != '0);

endmodule
